// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM states and the
// per-stage {we, flush} control pair with its three canonical encodings.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      EX_WAIT  = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic we;
      logic flush;
   } stage_ctl_t;

   // Flush is only honoured with we=1, so a bubble is always {1,1}.
   localparam stage_ctl_t STAGE_PASS   = '{we: 1'b1, flush: 1'b0};
   localparam stage_ctl_t STAGE_HOLD   = '{we: 1'b0, flush: 1'b0};
   localparam stage_ctl_t STAGE_BUBBLE = '{we: 1'b1, flush: 1'b1};

   function automatic logic is_flushing(input stage_ctl_t c);
      return c.we & c.flush;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: drives every pipeline
// register's we/flush pair, the PC enable and the data-memory request.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             ex_mc_start,
   input  logic             ex_mc_done,
   input  logic             mem_access,
   input  logic             dmem_ack,
   input  logic             exc_flush,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_we,
   output logic             id_ex_flush,
   output logic             ex_mem_we,
   output logic             ex_mem_flush,
   output logic             mem_wb_we,
   output logic             mem_wb_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output ctrl_state_t      dbg_state
);

   ctrl_state_t state;
   stage_ctl_t  if_id_c, id_ex_c, ex_mem_c, mem_wb_c;
   logic        mem_issue, mem_stall, ex_stall, load_use;
   logic        stall_inc, flush_inc;

   // A memory access may be issued from RUN or while an EX op is pending;
   // in MEM_WAIT the request is simply held until the ack arrives.
   assign mem_issue = mem_access && (state != MEM_WAIT);
   assign mem_stall = (mem_issue || (state == MEM_WAIT)) && !dmem_ack;
   assign ex_stall  = ((state == RUN) && ex_mc_start && !ex_mc_done) ||
                      ((state == EX_WAIT) && !ex_mc_done);
   assign load_use  = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else if (exc_flush) begin
         state <= RUN;
      end else begin
         case (state)
            RUN: begin
               if (mem_access && !dmem_ack)          state <= MEM_WAIT;
               else if (ex_mc_start && !ex_mc_done)  state <= EX_WAIT;
            end
            MEM_WAIT: begin
               if (dmem_ack) state <= RUN;
            end
            EX_WAIT: begin
               if (mem_access && !dmem_ack) state <= MEM_WAIT;
               else if (ex_mc_done)         state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   // Priority: exception > memory stall > EX stall > branch > load-use.
   always_comb begin
      pc_en    = 1'b1;
      dmem_req = 1'b0;
      if_id_c  = STAGE_PASS;
      id_ex_c  = STAGE_PASS;
      ex_mem_c = STAGE_PASS;
      mem_wb_c = STAGE_PASS;
      if (exc_flush) begin
         if_id_c  = STAGE_BUBBLE;
         id_ex_c  = STAGE_BUBBLE;
         ex_mem_c = STAGE_BUBBLE;
      end else begin
         dmem_req = (mem_issue || (state == MEM_WAIT)) && !rst;
         if (mem_stall) begin
            pc_en    = 1'b0;
            if_id_c  = STAGE_HOLD;
            id_ex_c  = STAGE_HOLD;
            ex_mem_c = STAGE_HOLD;
            mem_wb_c = STAGE_BUBBLE;
         end else if (ex_stall) begin
            pc_en    = 1'b0;
            if_id_c  = STAGE_HOLD;
            id_ex_c  = STAGE_HOLD;
            ex_mem_c = STAGE_BUBBLE;
         end else if (ex_branch_taken) begin
            if_id_c  = STAGE_BUBBLE;
            id_ex_c  = STAGE_BUBBLE;
         end else if (load_use) begin
            pc_en    = 1'b0;
            if_id_c  = STAGE_HOLD;
            id_ex_c  = STAGE_BUBBLE;
         end
      end
   end

   assign if_id_we     = if_id_c.we;
   assign if_id_flush  = if_id_c.flush;
   assign id_ex_we     = id_ex_c.we;
   assign id_ex_flush  = id_ex_c.flush;
   assign ex_mem_we    = ex_mem_c.we;
   assign ex_mem_flush = ex_mem_c.flush;
   assign mem_wb_we    = mem_wb_c.we;
   assign mem_wb_flush = mem_wb_c.flush;
   assign dbg_state    = state;

   assign stall_inc = !pc_en;
   assign flush_inc = is_flushing(if_id_c) | is_flushing(id_ex_c) |
                      is_flushing(ex_mem_c) | is_flushing(mem_wb_c);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and stall controller for the 5-stage RISC-V pipeline.
- Drives the write-enable/flush pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Resolves load-use hazards, taken-branch redirects, exception flushes, multi-cycle EX ops and data-memory wait states.
- Pipeline registers apply flush only when write enable is high, so a bubble is always driven as we=1, flush=1.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID
- ex_rd  in  REG_W  destination of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- ex_mc_start  in  1  multi-cycle op (mul/div) present in EX
- ex_mc_done  in  1  multi-cycle unit result ready
- mem_access  in  1  MEM instruction is a load/store
- dmem_ack  in  1  data memory completes the access
- exc_flush  in  1  exception/trap raised by MEM instruction
- dmem_req  out  1  request to data memory
- pc_en  out  1  PC update enable
- if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we, mem_wb_flush  out  1 each  pipeline register controls
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  cycles with any flush asserted

Behaviour:
- FSM states: RUN, MEM_WAIT, EX_WAIT. Reset -> RUN. Counters reset to 0. Outputs are combinational from state and inputs.
- Default in RUN with no event: all we=1, all flush=0, pc_en=1, dmem_req=0.
- Priority, highest first: exc_flush > memory stall > EX stall > branch redirect > load-use.
- exc_flush:
  - if_id, id_ex and ex_mem get we=1, flush=1; mem_wb passes normally (we=1, flush=0); pc_en=1 (trap vector).
  - FSM -> RUN from any state; dmem_req=0.
- Memory stall:
  - RUN with mem_access=1: dmem_req=1.
  - If dmem_ack is high the same cycle, there is no stall.
  - Otherwise stall and go to MEM_WAIT.
  - MEM_WAIT: dmem_req=1 is held, and the stall continues until dmem_ack=1. On ack, that cycle un-stalls and the FSM goes to RUN.
  - Stall encoding: pc_en=0; if_id, id_ex and ex_mem get we=0; mem_wb gets we=1, flush=1 (bubble).
- EX stall:
  - RUN with ex_mc_start=1 and ex_mc_done=0 -> EX_WAIT. EX_WAIT exits to RUN on ex_mc_done.
  - While stalled: pc_en=0; if_id and id_ex get we=0; ex_mem gets we=1, flush=1; mem_wb passes normally.
  - A single-cycle op (done with start) does not stall.
- If a memory stall and an EX stall overlap, the memory stall wins. The FSM remains in MEM_WAIT; an EX op still pending on exit is re-evaluated in RUN.
- Branch redirect (ex_branch_taken in RUN, no stall): if_id and id_ex get we=1, flush=1; pc_en=1. Load-use is suppressed because the ID instruction is squashed.
- Load-use hazard:
  - Condition: ex_mem_read and ex_rd!=0 and (ex_rd==id_rs1 or ex_rd==id_rs2).
  - Response: pc_en=0; if_id gets we=0; id_ex gets we=1, flush=1. Exactly one bubble per hazard.
- During any stall, ex_branch_taken is ignored. The branch stays in a frozen stage and is re-seen after release.
- Counters:
  - stall_cnt increments when pc_en=0.
  - flush_cnt increments when any *_flush output is 1 with its we=1.
  - Both saturate at all-ones and are cleared only by rst.
- Reset mid-wait: rst forces RUN, dmem_req=0 and counters=0 on the next edge. It overrides everything.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - ctrl_state_t enum (RUN, MEM_WAIT, EX_WAIT)
  - stage_ctl_t packed struct {we, flush}
  - constants STAGE_PASS={1,0}, STAGE_HOLD={0,0}, STAGE_BUBBLE={1,1}
- One sub-module, sat_counter (parameter CNT_W; ports clk, rst, inc, count), instantiated twice.

Test Plan:
- Load-use hazard. Stimulus: ex_mem_read=1, ex_rd=5, id_rs2=5. Response: one cycle of pc_en=0, if_id_we=0, id_ex_we=1/flush=1; stall_cnt=1, flush_cnt=1.
- x0 case. Stimulus: same as load-use but ex_rd=0. Response: no stall; all STAGE_PASS.
- Branch with load-use. Stimulus: ex_branch_taken=1 plus the load-use condition. Response: if_id and id_ex bubbled, pc_en=1, no stall.
- Memory wait. Stimulus: mem_access=1, dmem_ack low for 3 cycles then high. Response: dmem_req high for 4 cycles; pc_en=0 for 3; mem_wb bubble for 3; FSM back to RUN; stall_cnt=3.
- EX wait with exception. Stimulus: ex_mc_start=1 with done after 4 cycles, then exc_flush during EX_WAIT. Response: EX stall encoding until the exception; exception flush encoding that cycle; FSM=RUN next cycle.
- Saturation and reset. Stimulus: CNT_W=4, 20 stall cycles. Response: stall_cnt holds 15. Then assert rst mid-MEM_WAIT. Response: counters 0, dmem_req=0, state RUN next edge.
